// File: rtl/mem_access_pkg.sv
// Shared codes for the memory-access stage: store sizes, load funct3 values, FSM states.
// Also hosts the misalignment check used when MEM_ACCESS_MISALIGN_TRAP_EN is defined.
package mem_access_pkg;

    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        StoreNone = 2'b00,
        StoreByte = 2'b01,
        StoreHalf = 2'b10,
        StoreWord = 2'b11
    } store_mode_e;

    localparam logic [2:0] LoadLb  = 3'b000;
    localparam logic [2:0] LoadLh  = 3'b001;
    localparam logic [2:0] LoadLw  = 3'b010;
    localparam logic [2:0] LoadLbu = 3'b100;
    localparam logic [2:0] LoadLhu = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StWb   = 2'd2
    } state_e;

    // Undefined load codes act as LW, so they are checked as word accesses.
    function automatic logic is_misaligned(input logic       is_load,
                                           input logic [2:0] load_mode,
                                           input logic [1:0] store_mode,
                                           input logic [1:0] lane);
        logic r;
        r = 1'b0;
        if (is_load) begin
            case (load_mode)
                LoadLb, LoadLbu: r = 1'b0;
                LoadLh, LoadLhu: r = lane[0];
                default:         r = (lane != 2'b00);
            endcase
        end else begin
            case (store_mode)
                StoreHalf: r = lane[0];
                StoreWord: r = (lane != 2'b00);
                default:   r = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane steering: builds store strobes/data from size and address, and
// extracts plus sign/zero-extends load data from a bus word.
module mem_access_align
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]        i_store_mode,
    input  logic [1:0]        i_store_lane,
    input  logic [XLEN-1:0]   i_store_data,
    output logic [STRB_W-1:0] o_wstrb,
    output logic [XLEN-1:0]   o_wdata,
    input  logic [2:0]        i_load_mode,
    input  logic [1:0]        i_load_lane,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [XLEN-1:0]   o_load_data
);

    logic [7:0]  w_sbyte;
    logic [15:0] w_shalf;
    logic [7:0]  w_lbyte;
    logic [15:0] w_lhalf;

    assign w_sbyte = i_store_data[7:0];
    assign w_shalf = i_store_data[15:0];
    assign w_lbyte = i_rdata[{i_load_lane, 3'b000} +: 8];
    assign w_lhalf = i_rdata[{i_load_lane[1], 4'b0000} +: 16];

    // Sub-word stores replicate data into every lane; strobes select the target bytes.
    always_comb begin
        o_wstrb = '0;
        o_wdata = '0;
        case (i_store_mode)
            StoreByte: begin
                o_wstrb = 4'b0001 << i_store_lane;
                o_wdata = {(XLEN/8){w_sbyte}};
            end
            StoreHalf: begin
                o_wstrb = i_store_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {(XLEN/16){w_shalf}};
            end
            StoreWord: begin
                o_wstrb = 4'b1111;
                o_wdata = i_store_data;
            end
            default: begin
                o_wstrb = '0;
                o_wdata = '0;
            end
        endcase
    end

    always_comb begin
        o_load_data = i_rdata;
        case (i_load_mode)
            LoadLb:  o_load_data = {{(XLEN-8){w_lbyte[7]}}, w_lbyte};
            LoadLbu: o_load_data = {{(XLEN-8){1'b0}}, w_lbyte};
            LoadLh:  o_load_data = {{(XLEN-16){w_lhalf[15]}}, w_lhalf};
            LoadLhu: o_load_data = {{(XLEN-16){1'b0}}, w_lhalf};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one outstanding load/store on a req/ack data bus with timeout.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned half/word accesses with bus_err.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mem_load_en,
    input  logic [XLEN-1:0]   i_mem_load_addr,
    input  logic [2:0]        i_mem_load_mode,
    input  logic [4:0]        i_mem_load_regs_addr,
    input  logic [1:0]        i_mem_store_mode,
    input  logic [XLEN-1:0]   i_mem_store_addr,
    input  logic [XLEN-1:0]   i_mem_store_data,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [XLEN-1:0]   o_bus_addr,
    output logic [STRB_W-1:0] o_bus_wstrb,
    output logic [XLEN-1:0]   o_bus_wdata,
    input  logic [XLEN-1:0]   i_bus_rdata,
    input  logic              i_bus_ack,
    output logic              o_regs_write_en,
    output logic [4:0]        o_regs_write_addr,
    output logic [XLEN-1:0]   o_regs_write_data,
    output logic              o_pause_signal,
    output logic              o_bus_err
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUS_TIMEOUT - 1);

    state_e            r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic              r_err, w_err_d;
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [STRB_W-1:0] r_wstrb;
    logic [XLEN-1:0]   r_wdata;
    logic [2:0]        r_load_mode;
    logic [1:0]        r_lane;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_wb_data;

    logic              w_req;
    logic              w_accept;
    logic              w_misalign;
    logic [1:0]        w_lane_in;
    logic [XLEN-1:0]   w_addr_in;
    logic [1:0]        w_store_mode_in;
    logic [STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_data;

    // A simultaneous load wins; the store is dropped by treating its mode as none.
    assign w_req           = i_mem_load_en || (i_mem_store_mode != StoreNone);
    assign w_addr_in       = i_mem_load_en ? i_mem_load_addr : i_mem_store_addr;
    assign w_lane_in       = w_addr_in[1:0];
    assign w_store_mode_in = i_mem_load_en ? StoreNone : i_mem_store_mode;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(i_mem_load_en, i_mem_load_mode, i_mem_store_mode,
                                      w_lane_in);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = (r_state == StIdle) && w_req && !w_misalign;

    mem_access_align #(
        .XLEN(XLEN)
    ) u_align (
        .i_store_mode(w_store_mode_in),
        .i_store_lane(w_lane_in),
        .i_store_data(i_mem_store_data),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .i_load_mode (r_load_mode),
        .i_load_lane (r_lane),
        .i_rdata     (i_bus_rdata),
        .o_load_data (w_load_data)
    );

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_err_d   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req) begin
                    if (w_misalign) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_state_d = StBus;
                        w_cnt_d   = '0;
                    end
                end
            end
            StBus: begin
                if (i_bus_ack) begin
                    w_state_d = r_we ? StIdle : StWb;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_d = StIdle;
                    w_err_d   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StWb: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_load_mode <= '0;
            r_lane      <= '0;
            r_rd        <= '0;
            r_wb_data   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_err   <= w_err_d;
            if (w_accept) begin
                r_we        <= !i_mem_load_en;
                r_addr      <= {w_addr_in[XLEN-1:2], 2'b00};
                r_wstrb     <= w_wstrb;
                r_wdata     <= w_wdata;
                r_load_mode <= i_mem_load_mode;
                r_lane      <= w_lane_in;
                r_rd        <= i_mem_load_en ? i_mem_load_regs_addr : 5'd0;
            end
            if ((r_state == StBus) && i_bus_ack && !r_we) begin
                r_wb_data <= w_load_data;
            end
        end
    end

    assign o_bus_req         = (r_state == StBus);
    assign o_bus_we          = r_we;
    assign o_bus_addr        = r_addr;
    assign o_bus_wstrb       = r_wstrb;
    assign o_bus_wdata       = r_wdata;
    assign o_regs_write_en   = (r_state == StWb) && (r_rd != 5'd0);
    assign o_regs_write_addr = r_rd;
    assign o_regs_write_data = r_wb_data;
    assign o_bus_err         = r_err;
    // Reset is gated in so the stall drops in the same cycle the reset is applied.
    assign o_pause_signal    = i_rst && (((r_state == StIdle) && w_req) || (r_state == StBus));

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: stores, loads, priority, timeout, reset.
// Covers the trap path when MEM_ACCESS_MISALIGN_TRAP_EN is defined.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [31:0] load_addr;
    logic [2:0]  load_mode;
    logic [4:0]  load_rd;
    logic [1:0]  store_mode;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pause;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access #(
        .XLEN       (32),
        .BUS_TIMEOUT(16)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_mem_load_en       (load_en),
        .i_mem_load_addr     (load_addr),
        .i_mem_load_mode     (load_mode),
        .i_mem_load_regs_addr(load_rd),
        .i_mem_store_mode    (store_mode),
        .i_mem_store_addr    (store_addr),
        .i_mem_store_data    (store_data),
        .o_bus_req           (bus_req),
        .o_bus_we            (bus_we),
        .o_bus_addr          (bus_addr),
        .o_bus_wstrb         (bus_wstrb),
        .o_bus_wdata         (bus_wdata),
        .i_bus_rdata         (bus_rdata),
        .i_bus_ack           (bus_ack),
        .o_regs_write_en     (wr_en),
        .o_regs_write_addr   (wr_addr),
        .o_regs_write_data   (wr_data),
        .o_pause_signal      (pause),
        .o_bus_err           (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        load_en    = 1'b0;
        store_mode = 2'b00;
    endtask

    // Store with ack in the given BUS cycle (1 = first cycle).
    task automatic do_store(input string tag, input logic [1:0] mode, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input int ack_cycle);
        store_mode = mode;
        store_addr = addr;
        store_data = data;
        #1;
        check_eq({tag, "_pause_acc"}, 32'(pause), 32'd1);
        tick();
        clear_req();
        for (int c = 1; c <= ack_cycle; c++) begin
            check_eq({tag, "_req"}, 32'(bus_req), 32'd1);
            check_eq({tag, "_pause_bus"}, 32'(pause), 32'd1);
            check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
            if (c == 1) begin
                check_eq({tag, "_we"}, 32'(bus_we), 32'd1);
                check_eq({tag, "_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
                check_eq({tag, "_strb"}, 32'(bus_wstrb), 32'(exp_strb));
                check_eq({tag, "_wdata"}, bus_wdata, exp_wdata);
            end
            if (c == ack_cycle) bus_ack = 1'b1;
            tick();
            bus_ack = 1'b0;
        end
        check_eq({tag, "_req_done"}, 32'(bus_req), 32'd0);
        check_eq({tag, "_pause_done"}, 32'(pause), 32'd0);
        check_eq({tag, "_wr_en_done"}, 32'(wr_en), 32'd0);
    endtask

    // Load with immediate ack; rd=0 expects no writeback.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] mode,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_data);
        load_en   = 1'b1;
        load_addr = addr;
        load_mode = mode;
        load_rd   = rd;
        #1;
        check_eq({tag, "_pause_acc"}, 32'(pause), 32'd1);
        tick();
        clear_req();
        check_eq({tag, "_req"}, 32'(bus_req), 32'd1);
        check_eq({tag, "_we"}, 32'(bus_we), 32'd0);
        check_eq({tag, "_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
        bus_rdata = rdata;
        bus_ack   = 1'b1;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        check_eq({tag, "_req_wb"}, 32'(bus_req), 32'd0);
        check_eq({tag, "_pause_wb"}, 32'(pause), 32'd0);
        check_eq({tag, "_wr_en"}, 32'(wr_en), 32'(rd != 5'd0));
        if (rd != 5'd0) begin
            check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'(rd));
            check_eq({tag, "_wr_data"}, wr_data, exp_data);
        end
        tick();
        check_eq({tag, "_wr_en_after"}, 32'(wr_en), 32'd0);
    endtask

    initial begin
        int n_high;
        rst        = 1'b0;
        load_en    = 1'b0;
        load_addr  = 32'h0;
        load_mode  = 3'b000;
        load_rd    = 5'd0;
        store_mode = 2'b00;
        store_addr = 32'h0;
        store_data = 32'h0;
        bus_rdata  = 32'h0;
        bus_ack    = 1'b0;
        tick();
        tick();
        check_eq("rst_req", 32'(bus_req), 32'd0);
        check_eq("rst_pause", 32'(pause), 32'd0);
        check_eq("rst_err", 32'(bus_err), 32'd0);
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_addr", bus_addr, 32'h0);
        rst = 1'b1;
        tick();

        // Stray ack while idle must be ignored.
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check_eq("idle_ack_req", 32'(bus_req), 32'd0);
        check_eq("idle_ack_wr", 32'(wr_en), 32'd0);

        do_store("sb", 2'b01, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 2);
        do_store("sh", 2'b10, 32'h0000_1002, 32'h5555_1234, 4'b1100, 32'h1234_1234, 1);
        do_store("sw", 2'b11, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 3);

        do_load("lb1", 32'h0000_2001, 3'b000, 5'd5, 32'h0000_8000, 32'hFFFF_FF80);
        do_load("lb2", 32'h0000_2001, 3'b000, 5'd6, 32'h0000_F000, 32'hFFFF_FFF0);
        do_load("lbu", 32'h0000_2001, 3'b100, 5'd7, 32'h0000_8000, 32'h0000_0080);
        do_load("lh_x0", 32'h0000_2002, 3'b001, 5'd0, 32'h8000_0000, 32'hFFFF_8000);
        do_load("lh", 32'h0000_2002, 3'b001, 5'd8, 32'h8000_0000, 32'hFFFF_8000);
        do_load("lhu", 32'h0000_2000, 3'b101, 5'd9, 32'h1234_9ABC, 32'h0000_9ABC);
        do_load("lw", 32'h0000_2004, 3'b010, 5'd10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lundef", 32'h0000_2008, 3'b011, 5'd11, 32'h8765_4321, 32'h8765_4321);

        // Load and store together: only the load reaches the bus.
        load_en    = 1'b1;
        load_addr  = 32'h0000_3000;
        load_mode  = 3'b010;
        load_rd    = 5'd12;
        store_mode = 2'b11;
        store_addr = 32'h0000_4000;
        store_data = 32'h1111_1111;
        tick();
        clear_req();
        check_eq("both_addr", bus_addr, 32'h0000_3000);
        check_eq("both_we", 32'(bus_we), 32'd0);
        check_eq("both_strb", 32'(bus_wstrb), 32'd0);
        bus_rdata = 32'h0BAD_F00D;
        bus_ack   = 1'b1;
        tick();
        bus_ack = 1'b0;
        check_eq("both_wr_en", 32'(wr_en), 32'd1);
        check_eq("both_wr_data", wr_data, 32'h0BAD_F00D);
        tick();

        // Timeout: no ack for 16 BUS cycles.
        load_en   = 1'b1;
        load_addr = 32'h0000_6000;
        load_mode = 3'b010;
        load_rd   = 5'd3;
        tick();
        clear_req();
        n_high = 0;
        while (bus_req && n_high < 40) begin
            n_high++;
            check_eq("to_err_early", 32'(bus_err), 32'd0);
            tick();
        end
        check_eq("to_req_cycles", 32'(n_high), 32'd16);
        check_eq("to_err_pulse", 32'(bus_err), 32'd1);
        check_eq("to_wr_en", 32'(wr_en), 32'd0);
        check_eq("to_pause", 32'(pause), 32'd0);
        tick();
        check_eq("to_err_clear", 32'(bus_err), 32'd0);
        check_eq("to_wr_en2", 32'(wr_en), 32'd0);
        do_load("after_to", 32'h0000_2003, 3'b000, 5'd4, 32'h7F00_0000, 32'h0000_007F);

        // Reset while a store is on the bus.
        store_mode = 2'b11;
        store_addr = 32'h0000_7000;
        store_data = 32'h2222_3333;
        tick();
        check_eq("rstbus_req", 32'(bus_req), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rstbus_pause_now", 32'(pause), 32'd0);
        tick();
        check_eq("rstbus_req_off", 32'(bus_req), 32'd0);
        check_eq("rstbus_pause", 32'(pause), 32'd0);
        check_eq("rstbus_we", 32'(bus_we), 32'd0);
        check_eq("rstbus_addr", bus_addr, 32'h0);
        check_eq("rstbus_strb", 32'(bus_wstrb), 32'd0);
        check_eq("rstbus_wdata", bus_wdata, 32'h0);
        check_eq("rstbus_err", 32'(bus_err), 32'd0);
        clear_req();
        rst = 1'b1;
        tick();

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        store_mode = 2'b11;
        store_addr = 32'h0000_5002;
        store_data = 32'h4444_5555;
        #1;
        check_eq("trap_pause", 32'(pause), 32'd1);
        tick();
        clear_req();
        check_eq("trap_err", 32'(bus_err), 32'd1);
        check_eq("trap_req", 32'(bus_req), 32'd0);
        tick();
        check_eq("trap_err_clear", 32'(bus_err), 32'd0);
        check_eq("trap_req2", 32'(bus_req), 32'd0);
        check_eq("trap_wr_en", 32'(wr_en), 32'd0);
`else
        // Misaligned accesses proceed with the offending low bits ignored.
        do_store("sh_mis", 2'b10, 32'h0000_5003, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 1);
        do_store("sw_mis", 2'b11, 32'h0000_5002, 32'h4444_5555, 4'b1111, 32'h4444_5555, 1);
        do_load("lw_mis", 32'h0000_5003, 3'b010, 5'd13, 32'h1357_9BDF, 32'h1357_9BDF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
